narrow_sat_pipe: RTL and testbench

NARROW_SAT_PIPE -- requirements
Module: narrow_sat_pipe

---
 rtl/narrow_pkg.sv | 12 +
 rtl/narrow_sat_pipe_if.sv | 31 +++
 rtl/narrow_sat.sv | 28 ++
 rtl/narrow_sat_pipe.sv | 118 +++++++++++
 tb/tb_narrow_sat_pipe.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/narrow_pkg.sv
// narrow_pkg: shared types for the narrowing pipeline.
// Holds the rounding-mode encoding used on in_rnd.
package narrow_pkg;

  typedef enum logic [1:0] {
    RNU = 2'd0,
    RNE = 2'd1,
    RDN = 2'd2,
    ROD = 2'd3
  } rnd_mode_e;

endpackage

// File: rtl/narrow_sat_pipe_if.sv
// narrow_sat_pipe_if: input/output handshakes plus the saturation flag bundle.
// The master drives elements in and accepts results; the slave is the pipeline.
interface narrow_sat_pipe_if #(
  parameter int W_IN  = 12,
  parameter int W_OUT = 8
);

  logic                       in_valid;
  logic                       in_ready;
  logic [W_IN-1:0]            in_data;
  logic                       in_signed;
  logic [$clog2(W_IN)-1:0]    in_shift;
  logic [1:0]                 in_rnd;
  logic                       out_valid;
  logic                       out_ready;
  logic [W_OUT-1:0]           out_data;
  logic                       out_sat;
  logic                       sat_sticky;
  logic                       sat_clr;

  modport master (
    output in_valid, in_data, in_signed, in_shift, in_rnd, out_ready, sat_clr,
    input  in_ready, out_valid, out_data, out_sat, sat_sticky
  );

  modport slave (
    input  in_valid, in_data, in_signed, in_shift, in_rnd, out_ready, sat_clr,
    output in_ready, out_valid, out_data, out_sat, sat_sticky
  );

endinterface

// File: rtl/narrow_sat.sv
// narrow_sat: combinational clamp of a W_IN+1 bit value into W_OUT bits.
// Signed values clip to the two's complement range, unsigned to [0, 2^W_OUT-1].
module narrow_sat #(
  parameter int W_IN  = 12,
  parameter int W_OUT = 8
) (
  input  logic [W_IN:0]      val,
  input  logic               sgn,
  output logic [W_OUT-1:0]   res,
  output logic               sat
);

  // Fits as signed only if every bit from W_OUT-1 upward repeats the sign.
  always_comb begin
    res = val[W_OUT-1:0];
    sat = 1'b0;
    if (sgn) begin
      if (val[W_IN:W_OUT-1] != {(W_IN-W_OUT+2){val[W_IN]}}) begin
        sat = 1'b1;
        res = val[W_IN] ? {1'b1, {(W_OUT-1){1'b0}}} : {1'b0, {(W_OUT-1){1'b1}}};
      end
    end else if (|val[W_IN:W_OUT]) begin
      sat = 1'b1;
      res = '1;
    end
  end

endmodule

// File: rtl/narrow_sat_pipe.sv
// narrow_sat_pipe: two-stage shift/round (S1) then saturate (S2) narrowing pipeline.
// Define NARROW_ROUND_EN for RNU/RNE/ROD rounding; otherwise in_rnd is ignored and results truncate.
module narrow_sat_pipe
  import narrow_pkg::*;
#(
  parameter int W_IN  = 12,
  parameter int W_OUT = 8
) (
  input logic              clk,
  input logic              rst,
  narrow_sat_pipe_if.slave bus
);

  localparam int SW = $clog2(W_IN);
  localparam int FW = 1 << SW;
`ifdef NARROW_ROUND_EN
  localparam int S1W = W_IN + 1;
`else
  localparam int S1W = W_IN;
`endif

  logic signed [W_IN+FW:0] wide;
  logic [W_IN:0]           int_part;
  logic [FW-1:0]           frac;
  logic                    guard;
  logic                    sticky;
  logic [W_IN:0]           rounded;

  logic                    s1_valid;
  logic [S1W-1:0]          s1_val;
  logic                    s1_sgn;
  logic [W_IN:0]           sat_in;
  logic [W_OUT-1:0]        sat_data;
  logic                    sat_flag;
  logic                    s2_adv;

  // A zero fraction field below the element catches every shifted-out bit for rounding.
  always_comb begin
    wide     = $signed({bus.in_signed & bus.in_data[W_IN-1], bus.in_data, {FW{1'b0}}}) >>> bus.in_shift;
    int_part = wide[W_IN+FW:FW];
    frac     = wide[FW-1:0];
    guard    = frac[FW-1];
    sticky   = |frac[FW-2:0];
    rounded  = int_part;
`ifdef NARROW_ROUND_EN
    case (rnd_mode_e'(bus.in_rnd))
      RNU:     rounded = int_part + {{W_IN{1'b0}}, guard};
      RNE:     rounded = int_part + {{W_IN{1'b0}}, guard & (int_part[0] | sticky)};
      ROD:     rounded = {int_part[W_IN:1], int_part[0] | guard | sticky};
      default: rounded = int_part;
    endcase
`endif
  end

`ifndef NARROW_ROUND_EN
  logic unused_round;
  assign unused_round = ^{bus.in_rnd, guard, sticky, rounded[W_IN]};
`endif

  assign s2_adv       = !bus.out_valid | bus.out_ready;
  assign bus.in_ready = !s1_valid | s2_adv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_val   <= '0;
      s1_sgn   <= 1'b0;
    end else if (bus.in_ready) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_val <= rounded[S1W-1:0];
        s1_sgn <= bus.in_signed;
      end
    end
  end

`ifdef NARROW_ROUND_EN
  assign sat_in = s1_val;
`else
  assign sat_in = {s1_sgn & s1_val[W_IN-1], s1_val};
`endif

  narrow_sat #(
    .W_IN  (W_IN),
    .W_OUT (W_OUT)
  ) u_sat (
    .val (sat_in),
    .sgn (s1_sgn),
    .res (sat_data),
    .sat (sat_flag)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_sat   <= 1'b0;
    end else if (s2_adv) begin
      bus.out_valid <= s1_valid;
      if (s1_valid) begin
        bus.out_data <= sat_data;
        bus.out_sat  <= sat_flag;
      end
    end
  end

  // A saturating transfer outranks a clear landing on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.sat_sticky <= 1'b0;
    end else if (bus.out_valid & bus.out_ready & bus.out_sat) begin
      bus.sat_sticky <= 1'b1;
    end else if (bus.sat_clr) begin
      bus.sat_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_narrow_sat_pipe.sv
// tb_narrow_sat_pipe: directed and randomized checks of narrow_sat_pipe against an integer model.
// Expectations follow NARROW_ROUND_EN the same way the design build does.
module tb_narrow_sat_pipe;
  import narrow_pkg::*;

`ifdef NARROW_ROUND_EN
  localparam bit ROUND_EN = 1'b1;
`else
  localparam bit ROUND_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   out_count = 0;
  logic [8:0] exp_q[$];
  bit   sticky_exp = 1'b0;
  bit   hold_valid = 1'b0;
  logic [7:0] hold_data;
  logic hold_sat;

  narrow_sat_pipe_if #(.W_IN(12), .W_OUT(8)) bus();

  narrow_sat_pipe #(.W_IN(12), .W_OUT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Real-number view of the rules: floor-shift, then adjust by the discarded remainder.
  function automatic logic [8:0] modelNarrow(input logic [11:0] d, input bit s, input int sh, input int r);
    longint v, q, rem, half, lo, hi;
    bit sat;
    logic [7:0] res;
    v   = (s && d[11]) ? longint'(d) - 4096 : longint'(d);
    q   = v >>> sh;
    rem = v - (q <<< sh);
    if (ROUND_EN && sh > 0) begin
      half = longint'(1) <<< (sh - 1);
      case (r)
        0: if (rem >= half) q = q + 1;
        1: if (rem > half || (rem == half && q[0])) q = q + 1;
        3: if (rem != 0) q = q | 1;
        default: ;
      endcase
    end
    lo  = s ? -128 : 0;
    hi  = s ? 127 : 255;
    sat = 1'b0;
    if (q > hi) begin q = hi; sat = 1'b1; end
    if (q < lo) begin q = lo; sat = 1'b1; end
    res = q[7:0];
    return {sat, res};
  endfunction

  // Scoreboard: every transfer, held output and sticky value is checked mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      sticky_exp = 1'b0;
      hold_valid = 1'b0;
    end else begin
      checkOutput("sat_sticky", bus.sat_sticky, sticky_exp);
      if (hold_valid) begin
        checkOutput("hold_valid", bus.out_valid, 1);
        checkOutput("hold_data", bus.out_data, hold_data);
        checkOutput("hold_sat", bus.out_sat, hold_sat);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_output", 1, 0);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          checkOutput("out_data", bus.out_data, e[7:0]);
          checkOutput("out_sat", bus.out_sat, e[8]);
        end
        out_count++;
        if (bus.out_sat) sticky_exp = 1'b1;
        else if (bus.sat_clr) sticky_exp = 1'b0;
      end else if (bus.sat_clr) begin
        sticky_exp = 1'b0;
      end
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(modelNarrow(bus.in_data, bus.in_signed, int'(bus.in_shift), int'(bus.in_rnd)));
      hold_valid = bus.out_valid && !bus.out_ready;
      hold_data  = bus.out_data;
      hold_sat   = bus.out_sat;
    end
  end

  task automatic applyStimulus(input logic [11:0] d, input bit s, input int sh, input int r);
    bit acc;
    int n;
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_signed = s;
    bus.in_shift  = 4'(sh);
    bus.in_rnd    = 2'(r);
    acc = 1'b0;
    n = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #2;
      n++;
    end
    bus.in_valid = 1'b0;
    if (!acc) checkOutput("send_timeout", 0, 1);
  endtask

  task automatic run_directed(input string name, input logic [11:0] d, input bit s, input int sh,
                              input int r, input int exp_d, input int exp_s);
    logic [8:0] m;
    int n;
    bit seen;
    m = modelNarrow(d, s, sh, r);
    checkOutput({name, "_model_data"}, m[7:0], exp_d);
    checkOutput({name, "_model_sat"}, m[8], exp_s);
    applyStimulus(d, s, sh, r);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 10) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
      else n++;
    end
    checkOutput({name, "_latency"}, n, 1);
    checkOutput({name, "_data"}, bus.out_data, exp_d);
    checkOutput({name, "_sat"}, bus.out_sat, exp_s);
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [11:0] bp_data[3];
    int acc;
    int base;
    int n;
    bit last_ready;
    bit pending;

    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_signed = 1'b0;
    bus.in_shift = '0;
    bus.in_rnd = '0;
    bus.out_ready = 1'b1;
    bus.sat_clr = 1'b0;
    #3;
    checkOutput("reset_out_valid", bus.out_valid, 0);
    checkOutput("reset_out_data", bus.out_data, 0);
    checkOutput("reset_out_sat", bus.out_sat, 0);
    checkOutput("reset_sticky", bus.sat_sticky, 0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_reset", bus.in_ready, 1);
    @(posedge clk);
    #2;

    run_directed("neg2048", 12'h800, 1, 0, RNU, 8'h80, 1);
    @(negedge clk);
    checkOutput("sticky_set", bus.sat_sticky, 1);
    @(posedge clk);
    #2;
    run_directed("u300_sh1", 12'd300, 0, 1, RNU, 150, 0);
    run_directed("s300_sh1", 12'd300, 1, 1, RNU, 127, 1);
    run_directed("s7ff_rnu", 12'h7FF, 1, 4, RNU, 127, ROUND_EN ? 1 : 0);
    run_directed("ufff_rnu", 12'hFFF, 0, 4, RNU, 255, ROUND_EN ? 1 : 0);
    run_directed("ufff_rdn", 12'hFFF, 0, 4, RDN, 255, 0);
    run_directed("six_rne", 12'd6, 0, 2, RNE, ROUND_EN ? 2 : 1, 0);
    run_directed("ten_rne", 12'd10, 0, 2, RNE, 2, 0);
    run_directed("five_rod", 12'd5, 0, 1, ROD, ROUND_EN ? 3 : 2, 0);
    run_directed("five_rnu", 12'd5, 0, 1, RNU, ROUND_EN ? 3 : 2, 0);
    run_directed("five_rdn", 12'd5, 0, 1, RDN, 2, 0);

    // Backpressure: three offered against a stalled sink, only two fit.
    bp_data[0] = 12'd17;
    bp_data[1] = 12'd34;
    bp_data[2] = 12'd51;
    base = out_count;
    bus.out_ready = 1'b0;
    acc = 0;
    last_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      bus.in_valid  = (acc < 3);
      bus.in_data   = bp_data[(acc < 3) ? acc : 2];
      bus.in_signed = 1'b0;
      bus.in_shift  = '0;
      bus.in_rnd    = 2'(RDN);
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) acc++;
      last_ready = bus.in_ready;
      @(posedge clk);
      #2;
    end
    checkOutput("bp_accepted", acc, 2);
    checkOutput("bp_in_ready", last_ready, 0);
    checkOutput("bp_held_valid", bus.out_valid, 1);
    checkOutput("bp_held_data", bus.out_data, 17);
    bus.out_ready = 1'b1;
    n = 0;
    while (acc < 3 && n < 20) begin
      bus.in_valid = 1'b1;
      bus.in_data  = bp_data[acc];
      @(negedge clk);
      if (bus.in_ready) acc++;
      @(posedge clk);
      #2;
      n++;
    end
    bus.in_valid = 1'b0;
    n = 0;
    while (out_count < base + 3 && n < 20) begin
      @(posedge clk);
      #2;
      n++;
    end
    checkOutput("bp_drained", out_count - base, 3);

    // Clear the flag, then let a clear and a saturating transfer share an edge.
    bus.sat_clr = 1'b1;
    @(posedge clk);
    #2;
    bus.sat_clr = 1'b0;
    @(negedge clk);
    checkOutput("sticky_cleared", bus.sat_sticky, 0);
    @(posedge clk);
    #2;
    applyStimulus(12'h800, 1, 0, RDN);
    bus.sat_clr = 1'b1;
    n = 0;
    while (n < 10) begin
      @(negedge clk);
      if (bus.out_valid) break;
      n++;
    end
    @(posedge clk);
    #2;
    bus.sat_clr = 1'b0;
    @(negedge clk);
    checkOutput("set_beats_clear", bus.sat_sticky, 1);
    @(posedge clk);
    #2;

    // Reset with one element in S2 and one in S1.
    applyStimulus(12'd40, 0, 0, RDN);
    applyStimulus(12'd41, 0, 0, RDN);
    rst = 1'b1;
    #1;
    checkOutput("rst_out_valid", bus.out_valid, 0);
    checkOutput("rst_sticky", bus.sat_sticky, 0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_in_ready", bus.in_ready, 1);
    for (int c = 0; c < 5; c++) begin
      checkOutput("rst_no_stale", bus.out_valid, 0);
      @(negedge clk);
    end
    @(posedge clk);
    #2;

    // Random traffic with random sink stalls and occasional clears.
    pending = 1'b0;
    for (int c = 0; c < 600; c++) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.sat_clr   = ($urandom_range(0, 15) == 0);
      if (!pending && $urandom_range(0, 4) != 0) begin
        pending = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 12'($urandom_range(0, 4095));
        bus.in_signed = 1'($urandom_range(0, 1));
        bus.in_shift  = 4'($urandom_range(0, 15));
        bus.in_rnd    = 2'($urandom_range(0, 3));
      end
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) pending = 1'b0;
      @(posedge clk);
      #2;
      if (!pending) bus.in_valid = 1'b0;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.sat_clr = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk);
      #2;
      n++;
    end
    checkOutput("random_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
